dice_game_ctrl: RTL and testbench
=================================

Name: dice_game_ctrl

Overview:
Parametrised dice-game controller: the successor to the fixed two-die lab game. It supports NUM_DICE dice and a proper come-out/point state machine with rising-edge roll detection. It adds a point register, a new-round restart, and a multiplexed 7-segment scan over all dice. It sits behind the debounce and clock-divider blocks: rb arrives already debounced, and mHz is the game clock.

Parameters:
NUM_DICE, 2, number of dice and roll buttons (legal 2..4)
FACES, 6, die faces, values 1..FACES (legal 2..6)
NAT_A, 7, come-out instant-win sum
NAT_B, 11, second come-out instant-win sum
CRAPS_LO, 3, come-out loses if sum <= CRAPS_LO
CRAPS_HI, 12, come-out also loses if sum == CRAPS_HI
SEVEN_OUT, 7, point-phase losing sum
SCAN_DIV, 4, clocks each digit is held on the display (>=1)

Ports:
mHz  in  1  game clock, all state on rising edge
reset  in  1  asynchronous active-low reset
rb  in  NUM_DICE  debounced roll buttons, active-low (pressed = 0)
win  out  1  round won; held until next round
lose  out  1  round lost; held until next round
point_valid  out  1  game is in point phase
point  out  SUMW  established point, SUMW = clog2(NUM_DICE*FACES+1)
dice_flat  out  3*NUM_DICE  captured die values, die i at [3i+2:3i], 0 = not rolled
sel  out  max(1,clog2(NUM_DICE))  index of the die currently displayed
out  out  7  segment pattern {a,b,c,d,e,f,g} for die sel

Behaviour:
- Reset (reset=0, asynchronous):
  - win, lose, point_valid = 0; point = 0.
  - All dice = 0; rolled mask = 0; rb_prev = all ones.
  - State = COMEOUT; sel = 0; scan counter = 0.
  - out = 0000000.
  - Die counter i = (i mod FACES)+1.
- Die counters: each advances every clock, 1..FACES, wrapping FACES->1. They are never frozen.
- Press detect: press_i = rb_prev[i] & ~rb[i], with rb_prev registered every clock. A held button produces exactly one press.
- Capture: in COMEOUT/POINT, if press_i and rolled[i]=0, then at that edge dice[i] <= counter_i and rolled[i] <= 1. Further presses on a rolled die are ignored. Simultaneous presses on several dice all capture on the same edge.
- Evaluation: on the first edge where rolled is all ones, sum = unsigned SUMW-bit sum of dice. Outputs update at that edge, i.e. one clock after the last capture edge.
- State COMEOUT:
  - sum==NAT_A or NAT_B -> WIN, win<=1.
  - Else sum<=CRAPS_LO or sum==CRAPS_HI -> LOSE, lose<=1.
  - Else point<=sum, point_valid<=1, rolled<=0 -> POINT. Dice values are retained for display.
- State POINT:
  - sum==point -> WIN.
  - Else sum==SEVEN_OUT -> LOSE.
  - Else rolled<=0 and stay in POINT.
  - Point match has priority over seven-out.
- WIN/LOSE: terminal. Captures are disabled and all presses are ignored except press_0.
- press_0 in WIN/LOSE: at that edge, clear win, lose, point_valid, point, dice and rolled -> COMEOUT. The new round's first capture needs a fresh press.
- A capture edge never evaluates on the same edge; an evaluation edge never captures.
- Display scan:
  - The scan counter counts 0..SCAN_DIV-1. On wrap, sel increments and wraps NUM_DICE-1 -> 0.
  - out is registered from dice[sel] (one-clock lag): 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111.
  - Die value 0 or any other value -> 0000000.

Test Plan:
- Reset mid-POINT (reset=0 asynchronous, no clock edge) -> point_valid=0, point=0, dice_flat=0, out=0000000 immediately; state COMEOUT after release.
- Come-out natural: force capture of dice 3 and 4, pressed on separate cycles -> win=1 exactly one clock after the second capture; lose=0, point_valid=0.
- Come-out craps: dice 1+1 -> lose=1. Dice 6+6 -> lose=1. Dice 2+1 -> lose=1.
- Point then win: come-out 4+4 -> point=8, point_valid=1. Next roll 2+3 -> stay in POINT, rolled cleared. Next roll 5+3 -> win=1.
- Seven-out and button rules: point=6, then roll 3+4 -> lose=1. Holding rb[1] low for 50 clocks -> single capture. Second press on a rolled die -> value unchanged. press_0 in LOSE -> COMEOUT, outputs cleared.
- NUM_DICE=3, SCAN_DIV=2: sel sequence 0,0,1,1,2,2,0. Both simultaneous presses and rolled dice captured; out matches the pattern of dice[sel] one clock after sel changes. Sum 3+6+2=11 -> win.

Source files
------------

// File: rtl/dice_game_ctrl.sv
// ---------------------------------------------------------------------------
// dice_game_ctrl
//
// Parametrised dice-game controller. It has NUM_DICE free-running die
// counters, and each one is captured by a falling edge on its roll button.
// A come-out/point state machine scores each complete roll. A multiplexed
// 7-segment scan shows every captured die in turn.
//
// Ports:
//   mHz          game clock, all state updates on its rising edge
//   reset        asynchronous active-low reset
//   rb           debounced roll buttons, active-low (pressed = 0)
//   win          round won, held until the next round starts
//   lose         round lost, held until the next round starts
//   point_valid  game is in the point phase
//   point        established point
//   dice_flat    captured die values, die i at [3i+2:3i], 0 = not rolled
//   sel          index of the die currently shown on the display
//   out          segment pattern {a,b,c,d,e,f,g} for die sel
// ---------------------------------------------------------------------------
module dice_game_ctrl #(
    parameter int NUM_DICE  = 2,
    parameter int FACES     = 6,
    parameter int NAT_A     = 7,
    parameter int NAT_B     = 11,
    parameter int CRAPS_LO  = 3,
    parameter int CRAPS_HI  = 12,
    parameter int SEVEN_OUT = 7,
    parameter int SCAN_DIV  = 4,
    localparam int SUMW     = $clog2(NUM_DICE * FACES + 1),
    localparam int SELW     = (NUM_DICE > 1) ? $clog2(NUM_DICE) : 1
) (
    input  logic                  mHz,
    input  logic                  reset,
    input  logic [NUM_DICE-1:0]   rb,
    output logic                  win,
    output logic                  lose,
    output logic                  point_valid,
    output logic [SUMW-1:0]       point,
    output logic [3*NUM_DICE-1:0] dice_flat,
    output logic [SELW-1:0]       sel,
    output logic [6:0]            out
);

    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        COMEOUT = 2'd0,
        POINT   = 2'd1,
        WIN     = 2'd2,
        LOSE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  win_q, win_d;
    logic                  lose_q, lose_d;
    logic                  pv_q, pv_d;
    logic [SUMW-1:0]       point_q, point_d;
    logic [3*NUM_DICE-1:0] dice_q, dice_d;
    logic [NUM_DICE-1:0]   rolled_q, rolled_d;
    logic [NUM_DICE-1:0]   rb_prev_q;
    logic [3*NUM_DICE-1:0] cnt_q, cnt_d;
    logic [SCW-1:0]        scan_q, scan_d;
    logic [SELW-1:0]       sel_q, sel_d;
    logic [6:0]            out_q, out_d;

    logic [NUM_DICE-1:0]   press;
    logic                  all_rolled;
    logic [31:0]           sum_w;
    logic [2:0]            cur_die;

    function automatic logic [6:0] seg7(input logic [2:0] v);
        case (v)
            3'd1:    seg7 = 7'b0110000;
            3'd2:    seg7 = 7'b1101101;
            3'd3:    seg7 = 7'b1111001;
            3'd4:    seg7 = 7'b0110011;
            3'd5:    seg7 = 7'b1011011;
            3'd6:    seg7 = 7'b1011111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    // A press is a 1->0 transition, so a held button counts exactly once.
    assign press      = rb_prev_q & ~rb;
    assign all_rolled = &rolled_q;

    always_comb begin
        sum_w = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            sum_w = sum_w + 32'(dice_q[3*i +: 3]);
        end
    end

    // The die counters never freeze. The value a player captures depends only
    // on the clock edge at which the press lands.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_DICE; i++) begin
            if (cnt_q[3*i +: 3] == 3'(FACES)) begin
                cnt_d[3*i +: 3] = 3'd1;
            end else begin
                cnt_d[3*i +: 3] = cnt_q[3*i +: 3] + 3'd1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        lose_d   = lose_q;
        pv_d     = pv_q;
        point_d  = point_q;
        dice_d   = dice_q;
        rolled_d = rolled_q;

        case (state_q)
            COMEOUT, POINT: begin
                if (all_rolled) begin
                    // Evaluation edge: captures are impossible here because
                    // every die is already marked rolled.
                    if (state_q == COMEOUT) begin
                        if (sum_w == NAT_A || sum_w == NAT_B) begin
                            win_d   = 1'b1;
                            state_d = WIN;
                        end else if (sum_w <= CRAPS_LO || sum_w == CRAPS_HI) begin
                            lose_d  = 1'b1;
                            state_d = LOSE;
                        end else begin
                            point_d  = sum_w[SUMW-1:0];
                            pv_d     = 1'b1;
                            rolled_d = '0;
                            state_d  = POINT;
                        end
                    end else begin
                        // Matching the point takes priority over seven-out.
                        if (sum_w == 32'(point_q)) begin
                            win_d   = 1'b1;
                            state_d = WIN;
                        end else if (sum_w == SEVEN_OUT) begin
                            lose_d  = 1'b1;
                            state_d = LOSE;
                        end else begin
                            rolled_d = '0;
                        end
                    end
                end else begin
                    for (int i = 0; i < NUM_DICE; i++) begin
                        if (press[i] && !rolled_q[i]) begin
                            dice_d[3*i +: 3] = cnt_q[3*i +: 3];
                            rolled_d[i]      = 1'b1;
                        end
                    end
                end
            end
            WIN, LOSE: begin
                if (press[0]) begin
                    win_d    = 1'b0;
                    lose_d   = 1'b0;
                    pv_d     = 1'b0;
                    point_d  = '0;
                    dice_d   = '0;
                    rolled_d = '0;
                    state_d  = COMEOUT;
                end
            end
            default: state_d = COMEOUT;
        endcase
    end

    always_comb begin
        cur_die = 3'd0;
        for (int i = 0; i < NUM_DICE; i++) begin
            if (SELW'(i) == sel_q) begin
                cur_die = dice_q[3*i +: 3];
            end
        end
    end

    always_comb begin
        scan_d = scan_q + SCW'(1);
        sel_d  = sel_q;
        if (scan_q == SCW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            sel_d  = (sel_q == SELW'(NUM_DICE - 1)) ? '0 : sel_q + SELW'(1);
        end
        // The pattern is registered from the current sel, so it trails sel by a clock.
        out_d = seg7(cur_die);
    end

    always_ff @(posedge mHz or negedge reset) begin
        if (!reset) begin
            state_q   <= COMEOUT;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            pv_q      <= 1'b0;
            point_q   <= '0;
            dice_q    <= '0;
            rolled_q  <= '0;
            rb_prev_q <= '1;
            scan_q    <= '0;
            sel_q     <= '0;
            out_q     <= '0;
            for (int i = 0; i < NUM_DICE; i++) begin
                cnt_q[3*i +: 3] <= 3'((i % FACES) + 1);
            end
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            pv_q      <= pv_d;
            point_q   <= point_d;
            dice_q    <= dice_d;
            rolled_q  <= rolled_d;
            rb_prev_q <= rb;
            cnt_q     <= cnt_d;
            scan_q    <= scan_d;
            sel_q     <= sel_d;
            out_q     <= out_d;
        end
    end

    assign win         = win_q;
    assign lose        = lose_q;
    assign point_valid = pv_q;
    assign point       = point_q;
    assign dice_flat   = dice_q;
    assign sel         = sel_q;
    assign out         = out_q;

endmodule

// File: tb/tb_dice_game_ctrl.sv
module tb_dice_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] rb_a = 2'b11;
    logic [2:0] rb_b = 3'b111;

    logic       win_a, lose_a, pv_a;
    logic [3:0] point_a;
    logic [5:0] dice_a;
    logic [0:0] sel_a;
    logic [6:0] out_a;

    logic       win_b, lose_b, pv_b;
    logic [4:0] point_b;
    logic [8:0] dice_b;
    logic [1:0] sel_b;
    logic [6:0] out_b;

    int total = 0;
    int bad   = 0;

    // Reference die counters, stepped independently of the DUT.
    int ma [2];
    int mb [3];

    always #5 clk = ~clk;

    dice_game_ctrl u_a (
        .mHz(clk), .reset(rst_n), .rb(rb_a),
        .win(win_a), .lose(lose_a), .point_valid(pv_a), .point(point_a),
        .dice_flat(dice_a), .sel(sel_a), .out(out_a)
    );

    dice_game_ctrl #(.NUM_DICE(3), .SCAN_DIV(2)) u_b (
        .mHz(clk), .reset(rst_n), .rb(rb_b),
        .win(win_b), .lose(lose_b), .point_valid(pv_b), .point(point_b),
        .dice_flat(dice_b), .sel(sel_b), .out(out_b)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) ma[i] <= (i % 6) + 1;
            for (int i = 0; i < 3; i++) mb[i] <= (i % 6) + 1;
        end else begin
            for (int i = 0; i < 2; i++) ma[i] <= (ma[i] == 6) ? 1 : ma[i] + 1;
            for (int i = 0; i < 3; i++) mb[i] <= (mb[i] == 6) ? 1 : mb[i] + 1;
        end
    end

    function automatic logic [6:0] seg_ref(input int v);
        case (v)
            1:       return 7'b0110000;
            2:       return 7'b1101101;
            3:       return 7'b1111001;
            4:       return 7'b0110011;
            5:       return 7'b1011011;
            6:       return 7'b1011111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Press die 'die' of DUT A so that it captures value 'val'. Returns on the
    // falling edge just after the capture edge, with the button released.
    task automatic press_a(input int die, input int val);
        for (int k = 0; k < 14 && ma[die] != val; k++) @(negedge clk);
        if (ma[die] != val) begin
            total++; bad++;
            $display("FAIL press_a_timeout die=%0d required=%0d", die, val);
        end
        rb_a[die] = 1'b0;
        @(negedge clk);
        rb_a[die] = 1'b1;
    endtask

    task automatic roll_a(input int v0, input int v1);
        press_a(0, v0);
        press_a(1, v1);
        chk("no_eval_on_capture_win", win_a, 0);
        chk("no_eval_on_capture_lose", lose_a, 0);
        @(negedge clk);
    endtask

    task automatic restart_a();
        rb_a[0] = 1'b0;
        @(negedge clk);
        rb_a[0] = 1'b1;
        chk("restart_win", win_a, 0);
        chk("restart_lose", lose_a, 0);
        chk("restart_pv", pv_a, 0);
        chk("restart_point", point_a, 0);
        chk("restart_dice", dice_a, 0);
        @(negedge clk);
    endtask

    typedef struct {
        int v0; int v1; int w; int l; int pv; int pt;
    } vec_t;

    vec_t tbl [6];
    int   sel_exp [7];
    int   dv [3];
    int   s;

    initial begin
        tbl[0] = '{3, 4, 1, 0, 0, 0};
        tbl[1] = '{1, 1, 0, 1, 0, 0};
        tbl[2] = '{6, 6, 0, 1, 0, 0};
        tbl[3] = '{2, 1, 0, 1, 0, 0};
        tbl[4] = '{6, 5, 1, 0, 0, 0};
        tbl[5] = '{4, 4, 0, 0, 1, 8};
        sel_exp = '{0, 0, 1, 1, 2, 2, 0};
        dv = '{2, 3, 6};

        repeat (2) @(negedge clk);
        chk("rst_win", win_a, 0);
        chk("rst_lose", lose_a, 0);
        chk("rst_pv", pv_a, 0);
        chk("rst_point", point_a, 0);
        chk("rst_dice", dice_a, 0);
        chk("rst_out", out_a, 0);
        chk("rst_sel_b", sel_b, 0);
        chk("rst_out_b", out_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Come-out outcomes, last entry leaves DUT A in the point phase.
        for (int n = 0; n < 6; n++) begin
            roll_a(tbl[n].v0, tbl[n].v1);
            chk($sformatf("tbl%0d_win", n), win_a, tbl[n].w);
            chk($sformatf("tbl%0d_lose", n), lose_a, tbl[n].l);
            chk($sformatf("tbl%0d_pv", n), pv_a, tbl[n].pv);
            chk($sformatf("tbl%0d_point", n), point_a, tbl[n].pt);
            chk($sformatf("tbl%0d_dice", n), dice_a, {3'(tbl[n].v1), 3'(tbl[n].v0)});
            if (tbl[n].w != 0 || tbl[n].l != 0) restart_a();
        end

        // Point 8: a 5 keeps the point, then 8 wins.
        roll_a(2, 3);
        chk("pt_stay_pv", pv_a, 1);
        chk("pt_stay_point", point_a, 8);
        chk("pt_stay_win", win_a, 0);
        chk("pt_stay_lose", lose_a, 0);
        roll_a(5, 3);
        chk("pt_hit_win", win_a, 1);
        chk("pt_hit_lose", lose_a, 0);
        restart_a();

        // Point 6, repeated press on a rolled die, held button, seven-out.
        roll_a(2, 4);
        chk("p6_pv", pv_a, 1);
        chk("p6_point", point_a, 6);
        press_a(0, 3);
        chk("p6_die0", dice_a[2:0], 3);
        press_a(0, 5);
        chk("p6_die0_repress", dice_a[2:0], 3);
        chk("p6_repress_lose", lose_a, 0);
        for (int k = 0; k < 14 && ma[1] != 4; k++) @(negedge clk);
        rb_a[1] = 1'b0;
        repeat (50) @(negedge clk);
        rb_a[1] = 1'b1;
        chk("seven_out_lose", lose_a, 1);
        chk("seven_out_win", win_a, 0);
        chk("seven_out_dice", dice_a, 6'b100_011);
        @(negedge clk);
        rb_a[1] = 1'b0;
        @(negedge clk);
        rb_a[1] = 1'b1;
        chk("lose_ignore_die1", lose_a, 1);
        chk("lose_ignore_dice", dice_a, 6'b100_011);
        @(negedge clk);
        // Button 0 held through the restart must not also capture die 0.
        rb_a[0] = 1'b0;
        repeat (50) @(negedge clk);
        rb_a[0] = 1'b1;
        chk("hold0_lose", lose_a, 0);
        chk("hold0_pv", pv_a, 0);
        chk("hold0_dice", dice_a, 0);
        @(negedge clk);

        // Asynchronous reset in the middle of a point round.
        roll_a(4, 4);
        chk("pre_rst_pv", pv_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pv", pv_a, 0);
        chk("async_rst_point", point_a, 0);
        chk("async_rst_dice", dice_a, 0);
        chk("async_rst_out", out_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            chk($sformatf("sel_b_%0d", k), sel_b, sel_exp[k]);
            @(negedge clk);
        end

        roll_a(3, 4);
        chk("post_rst_comeout_win", win_a, 1);
        chk("post_rst_comeout_pv", pv_a, 0);
        restart_a();

        // Three dice: dice 0 and 1 together, then die 2; 2+3+6 = 11.
        for (int k = 0; k < 14 && mb[0] != 2; k++) @(negedge clk);
        chk("b_model_die1", mb[1], 3);
        rb_b[1:0] = 2'b00;
        @(negedge clk);
        rb_b = 3'b111;
        chk("b_simul_dice", dice_b[5:0], {3'd3, 3'd2});
        for (int k = 0; k < 14 && mb[2] != 6; k++) @(negedge clk);
        rb_b[2] = 1'b0;
        @(negedge clk);
        rb_b[2] = 1'b1;
        chk("b_capture_win", win_b, 0);
        @(negedge clk);
        chk("b_win", win_b, 1);
        chk("b_lose", lose_b, 0);
        chk("b_dice", dice_b, {3'd6, 3'd3, 3'd2});
        for (int k = 0; k < 6; k++) begin
            s = int'(sel_b);
            @(negedge clk);
            chk($sformatf("b_out_%0d", k), out_b, seg_ref(dv[s]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
